// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy flags, sticky errors and optional FWFT read.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); a write at full is taken only alongside a pop.
module param_fifo #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     WE,
  input  logic                     RE,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     half_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of 2 and at least 4");
    end
    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < DEPTH)) begin : g_bad_thresh
      $error("param_fifo: thresholds must satisfy 0 < AE_THRESH < AF_THRESH < DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, half_q, af_q, ae_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          rd_acc, wr_acc;

  // A full FIFO can still take a write when a pop frees the head slot in the same cycle.
  assign rd_acc = RE & ~empty_q;
  assign wr_acc = WE & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (WE & ~wr_acc) ovf_d = 1'b1;
    if (RE & ~rd_acc) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      half_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      half_q   <= (count_d >= CW'(DEPTH / 2));
      af_q     <= (count_d >= CW'(AF_THRESH));
      ae_q     <= (count_d <= CW'(AE_THRESH));
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because the read path is gated by count.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem_q[wr_ptr_q] <= write_data;
  end

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [WIDTH-1:0] rdata_q;
      logic             rvld_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          rdata_q <= '0;
          rvld_q  <= 1'b0;
        end else begin
          rvld_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
        end
      end
      assign read_data  = rdata_q;
      assign read_valid = rvld_q;
    end else begin : g_fwft_rd
      assign read_data  = empty_q ? '0 : mem_q[rd_ptr_q];
      assign read_valid = ~empty_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign half_full    = half_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: registered-read and FWFT instances checked against queue-based models.
module tb_param_fifo;
  localparam int W  = 36;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, we, re, clr, fwe, fre;
  logic [W-1:0] wd, fwd;

  logic [W-1:0] rd, frd;
  logic         rv, frv;
  logic [5:0]   cnt, fcnt;
  logic         full, empty, half, af, ae, ovf, unf;
  logic         ffull, fempty, fhalf, faf, fae, fovf, funf;

  param_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .WE(we), .RE(re), .write_data(wd), .clr_err(clr),
    .read_data(rd), .read_valid(rv), .count(cnt), .full(full), .empty(empty),
    .half_full(half), .almost_full(af), .almost_empty(ae), .overflow(ovf), .underflow(unf));

  param_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fw (
    .clk(clk), .reset(reset), .WE(fwe), .RE(fre), .write_data(fwd), .clr_err(clr),
    .read_data(frd), .read_valid(frv), .count(fcnt), .full(ffull), .empty(fempty),
    .half_full(fhalf), .almost_full(faf), .almost_empty(fae), .overflow(fovf), .underflow(funf));

  logic [W-1:0] q[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] m_rd;
  bit           m_rv, m_ov, m_un, f_ov, f_un;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply current inputs, advance the models, compare every output.
  task automatic cycle();
    bit racc, wacc;
    @(posedge clk);
    #1;
    if (!reset) begin
      q.delete(); fq.delete();
      m_rd = '0; m_rv = 0; m_ov = 0; m_un = 0; f_ov = 0; f_un = 0;
    end else begin
      racc = re && q.size() != 0;
      wacc = we && (q.size() < D || racc);
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(wd);
      m_ov = (we && !wacc) ? 1'b1 : (clr ? 1'b0 : m_ov);
      m_un = (re && !racc) ? 1'b1 : (clr ? 1'b0 : m_un);

      racc = fre && fq.size() != 0;
      wacc = fwe && (fq.size() < D || racc);
      if (racc) void'(fq.pop_front());
      if (wacc) fq.push_back(fwd);
      f_ov = (fwe && !wacc) ? 1'b1 : (clr ? 1'b0 : f_ov);
      f_un = (fre && !racc) ? 1'b1 : (clr ? 1'b0 : f_un);
    end
    check("count", cnt, q.size());
    check("full", full, q.size() == D);
    check("empty", empty, q.size() == 0);
    check("half_full", half, q.size() >= D / 2);
    check("almost_full", af, q.size() >= AF);
    check("almost_empty", ae, q.size() <= AE);
    check("overflow", ovf, m_ov);
    check("underflow", unf, m_un);
    check("read_valid", rv, m_rv);
    check("read_data", rd, m_rd);
    check("fw_count", fcnt, fq.size());
    check("fw_full", ffull, fq.size() == D);
    check("fw_empty", fempty, fq.size() == 0);
    check("fw_half_full", fhalf, fq.size() >= D / 2);
    check("fw_almost_full", faf, fq.size() >= AF);
    check("fw_almost_empty", fae, fq.size() <= AE);
    check("fw_overflow", fovf, f_ov);
    check("fw_underflow", funf, f_un);
    check("fw_read_valid", frv, fq.size() != 0);
    if (fq.size() != 0) check("fw_read_data", frd, fq[0]);
  endtask

  task automatic step(bit w, bit r, logic [W-1:0] d);
    we = w; re = r; wd = d;
    cycle();
    we = 0; re = 0;
  endtask

  initial begin
    reset = 0; we = 0; re = 0; wd = '0; clr = 0; fwe = 0; fre = 0; fwd = '0;

    // Writes presented during reset must be ignored.
    step(1, 0, 36'h5);
    step(1, 0, 36'h5);
    check("rst_count", cnt, 0);
    reset = 1;

    for (int i = 0; i < D; i++) step(1, 0, W'(i));
    step(1, 0, 36'h99);
    check("ovf_after_33rd", ovf, 1);
    clr = 1; step(0, 0, '0); clr = 0;

    for (int i = 0; i < D; i++) step(0, 1, '0);
    check("last_drained", rd, 31);
    step(0, 1, '0);
    check("unf_after_extra", unf, 1);
    clr = 1; step(0, 0, '0); clr = 0;

    for (int i = 0; i < D; i++) step(1, 0, W'(100 + i));
    step(1, 1, 36'hABC);
    check("full_rw_count", cnt, D);
    for (int i = 0; i < D; i++) step(0, 1, '0);
    check("abc_last", rd, 36'hABC);

    for (int i = 0; i < 20; i++) step(1, 0, W'(200 + i));
    for (int i = 0; i < 20; i++) step(0, 1, '0);
    for (int i = 0; i < 20; i++) step(1, 0, W'(300 + i));
    for (int i = 0; i < 20; i++) step(0, 1, '0);
    for (int i = 0; i < 10; i++) step(1, 0, W'(400 + i));
    reset = 0; step(1, 1, 36'h7); reset = 1;
    check("mid_rst_count", cnt, 0);

    // FWFT: word written into an empty FIFO shows up the next cycle without a pop.
    fwe = 1; fwd = 36'hA5; cycle(); fwe = 0;
    check("fwft_head", frd, 36'hA5);
    check("fwft_valid", frv, 1);
    fre = 1; cycle(); fre = 0;

    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = (n / 250) % 3;
      we  = $urandom_range(0, 99) < (bias == 0 ? 75 : (bias == 1 ? 25 : 50));
      re  = $urandom_range(0, 99) < (bias == 0 ? 25 : (bias == 1 ? 75 : 50));
      wd  = {$urandom(), $urandom()};
      fwe = $urandom_range(0, 99) < (bias == 1 ? 70 : 35);
      fre = $urandom_range(0, 99) < (bias == 1 ? 30 : 60);
      fwd = {$urandom(), $urandom()};
      clr = $urandom_range(0, 99) < 3;
      reset = !($urandom_range(0, 999) < 4);
      cycle();
    end
    we = 0; re = 0; fwe = 0; fre = 0; clr = 0; reset = 1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
